// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared states and constants for the ROM loader
package rom_loader_pkg;

    // Frame start marker used when the instantiating design does not override it
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Width of the word-count field carried by LEN_HI/LEN_LO
    localparam int LEN_WIDTH = 16;

    // Width of one serial byte
    localparam int BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CHECK  = 3'd5,
        DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/rom_loader_if.sv
// rtl/rom_loader_if.sv - byte-stream input and ROM write port bundle
interface rom_loader_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
) ();

    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic [ADDRESS_WIDTH-1:0] writeAddr;
    logic [DATA_WIDTH-1:0]    dataIn;
    logic                     wEn;
    logic                     loading;
    logic                     done;
    logic                     err;

    // Loader side: consumes bytes, drives the ROM port and status
    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output writeAddr,
        output dataIn,
        output wEn,
        output loading,
        output done,
        output err
    );

    // Environment side: serial receiver plus ROM and CPU reset logic
    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  writeAddr,
        input  dataIn,
        input  wEn,
        input  loading,
        input  done,
        input  err
    );

endinterface

// File: rtl/rom_loader_word_assembler.sv
// rtl/rom_loader_word_assembler.sv - MSB-first byte-to-word shift register
module word_assembler
    import rom_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  last_o
);

    localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    // Word as it stands once the incoming byte is appended, so the caller
    // can capture a complete word in the same cycle as the last byte
    assign word_o = (shift_q << BYTE_WIDTH) | DATA_WIDTH'(byte_data_i);
    assign last_o = byte_valid_i && (idx_q == IDX_W'(BYTES - 1));

    // Next shift contents and byte position; clear realigns to a word boundary
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clear_i) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (byte_valid_i) begin
            shift_d = word_o;
            idx_d   = last_o ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Shift register and byte index storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - framed byte-stream ROM writer; trailing checksum byte enabled by ROM_LOADER_CHECKSUM_EN
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int         DATA_WIDTH    = 32,
    parameter int         ADDRESS_WIDTH = 12,
    parameter int         DEPTH         = 4096,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    rom_loader_if.master bus
);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [LEN_WIDTH:0]       remain_q, remain_d;
    logic [7:0]               len_hi_q, len_hi_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]               csum_q, csum_d;
`endif

    logic                     rx_ready;
    logic                     accept;
    logic                     asm_valid;
    logic                     asm_clear;
    logic [DATA_WIDTH-1:0]    asm_word;
    logic                     asm_last;
    logic [LEN_WIDTH-1:0]     len_n;

    assign rx_ready  = (state_q != WRITE);
    assign accept    = bus.rx_valid && rx_ready;
    assign len_n     = {len_hi_q, bus.rx_data};
    assign asm_valid = accept && (state_q == DATA);
    // Outside DATA the assembler is held at a word boundary, so every frame
    // and every word after a write starts from byte 0
    assign asm_clear = (state_q != DATA);

    word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_assembler (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_valid),
        .byte_data_i  (bus.rx_data),
        .word_o       (asm_word),
        .last_o       (asm_last)
    );

    // Frame parser: next state, counters, captured word and sticky flags
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        remain_d = remain_q;
        len_hi_d = len_hi_q;
        done_d   = done_q;
        err_d    = err_q;
`ifdef ROM_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept && (bus.rx_data == SYNC_BYTE)) begin
                    state_d = LEN_HI;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_hi_d = bus.rx_data;
                    state_d  = LEN_LO;
`ifdef ROM_LOADER_CHECKSUM_EN
                    csum_d   = csum_q ^ bus.rx_data;
`endif
                end
            end
            LEN_LO: begin
                if (accept) begin
                    addr_d   = '0;
                    remain_d = {1'b0, len_n};
`ifdef ROM_LOADER_CHECKSUM_EN
                    csum_d   = csum_q ^ bus.rx_data;
`endif
                    if (len_n == '0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else if ({1'b0, len_n} > (LEN_WIDTH + 1)'(DEPTH)) begin
                        // Oversized frame is rejected before any write
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.rx_data;
`endif
                    if (asm_last) begin
                        data_d  = asm_word;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                remain_d = remain_q - (LEN_WIDTH + 1)'(1);
                if (remain_q == (LEN_WIDTH + 1)'(1)) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    addr_d  = addr_q + ADDRESS_WIDTH'(1);
                    state_d = DATA;
                end
            end
            CHECK: begin
`ifdef ROM_LOADER_CHECKSUM_EN
                if (accept) begin
                    if (bus.rx_data == csum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // done rises on the same edge loading falls, i.e. when DONE is entered
        if ((state_d == DONE) && (state_q != DONE)) begin
            done_d = 1'b1;
        end
    end

    // Parser registers; reset mid-frame abandons the frame without writing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            remain_q <= '0;
            len_hi_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            remain_q <= remain_d;
            len_hi_q <= len_hi_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign bus.rx_ready  = rx_ready;
    assign bus.wEn       = (state_q == WRITE);
    assign bus.writeAddr = addr_q;
    assign bus.dataIn    = data_q;
    assign bus.loading   = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                           (state_q == DATA)   || (state_q == WRITE)  ||
                           (state_q == CHECK);
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - randomized self-checking bench for rom_loader
module tb_rom_loader;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    rom_loader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    rom_loader #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .DEPTH         (DEPTH),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] rom [0:DEPTH-1];
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          acc_cyc_q[$];
    int          wen_cyc_q[$];
    int          cyc = 0;
    int          ready_in_write = 0;
    logic [31:0] fw[$];
    logic [7:0]  bq[$];

    // Observer: ROM model and logs of accepted bytes and write strobes
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (bus.rx_valid && bus.rx_ready) acc_cyc_q.push_back(cyc);
            if (bus.wEn) begin
                rom[bus.writeAddr] = bus.dataIn;
                wr_addr_q.push_back(int'(bus.writeAddr));
                wr_data_q.push_back(bus.dataIn);
                wen_cyc_q.push_back(cyc);
                if (bus.rx_ready) ready_in_write++;
            end
        end
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        acc_cyc_q.delete();
        wen_cyc_q.delete();
        ready_in_write = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int g;
        int t;
        g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        if (g > 0) begin
            bus.rx_valid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t = 0;
        while (!bus.rx_ready && t < 20) begin @(posedge clk); #1; t++; end
        if (t >= 20) begin
            n_cmp++; n_bad++;
            $display("FAIL rx_ready_timeout: rx_ready stayed 0 for %0d cycles, required 1", t);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_bq(input int max_gap);
        foreach (bq[i]) send_byte(bq[i], max_gap);
        bus.rx_valid = 1'b0;
    endtask

    task automatic settle();
        bus.rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Serialise fw[] as a frame: sync, length, words MSB first, optional checksum
    task automatic build_frame();
        int          n;
        logic [7:0]  cs;
        logic [31:0] w;
        n = fw.size();
        bq.delete();
        bq.push_back(8'hA5);
        bq.push_back(n[15:8]);
        bq.push_back(n[7:0]);
        cs = n[15:8] ^ n[7:0];
        foreach (fw[i]) begin
            w = fw[i];
            for (int b = 3; b >= 0; b--) begin
                bq.push_back(w[b*8 +: 8]);
                cs = cs ^ w[b*8 +: 8];
            end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        bq.push_back(cs);
`endif
    endtask

    task automatic random_words(input int n);
        fw.delete();
        for (int i = 0; i < n; i++) fw.push_back($urandom);
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.wEn, bus.loading, bus.done, bus.err, bus.rx_ready} !== 5'b00001) begin
            n_bad++;
            $display("FAIL reset_flags: wEn,loading,done,err,rx_ready=%b required 00001",
                     {bus.wEn, bus.loading, bus.done, bus.err, bus.rx_ready});
        end
        n_cmp++;
        if (bus.writeAddr !== 12'h000) begin
            n_bad++; $display("FAIL reset_addr: got %0h required 0", bus.writeAddr);
        end
        n_cmp++;
        if (bus.dataIn !== 32'h0) begin
            n_bad++; $display("FAIL reset_data: got %0h required 0", bus.dataIn);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        clear_logs();
        fw.delete();
        fw.push_back(32'hDEADBEEF);
        fw.push_back(32'h01020304);
        build_frame();
        send_bq(0);
        settle();
        n_cmp++;
        if (wr_data_q.size() !== 2) begin
            n_bad++; $display("FAIL basic_wen_count: got %0d required 2", wr_data_q.size());
        end else begin
            n_cmp++;
            if (wr_addr_q[0] !== 0 || wr_data_q[0] !== 32'hDEADBEEF) begin
                n_bad++;
                $display("FAIL basic_word0: addr %0d data %0h required addr 0 data deadbeef",
                         wr_addr_q[0], wr_data_q[0]);
            end
            n_cmp++;
            if (wr_addr_q[1] !== 1 || wr_data_q[1] !== 32'h01020304) begin
                n_bad++;
                $display("FAIL basic_word1: addr %0d data %0h required addr 1 data 01020304",
                         wr_addr_q[1], wr_data_q[1]);
            end
        end
        n_cmp++;
        if ({bus.done, bus.err, bus.loading} !== 3'b100) begin
            n_bad++;
            $display("FAIL basic_flags: done,err,loading=%b required 100",
                     {bus.done, bus.err, bus.loading});
        end
    endtask

    task automatic test_garbage();
        clear_logs();
        fw.delete();
        fw.push_back(32'h11223344);
        build_frame();
        bq.push_front(8'h12);
        bq.push_front(8'hFF);
        bq.push_front(8'h00);
        send_bq(2);
        settle();
        n_cmp++;
        if (wr_data_q.size() !== 1) begin
            n_bad++; $display("FAIL garbage_wen_count: got %0d required 1", wr_data_q.size());
        end else begin
            n_cmp++;
            if (wr_addr_q[0] !== 0 || wr_data_q[0] !== 32'h11223344) begin
                n_bad++;
                $display("FAIL garbage_word: addr %0d data %0h required addr 0 data 11223344",
                         wr_addr_q[0], wr_data_q[0]);
            end
        end
        n_cmp++;
        if (bus.done !== 1'b1) begin
            n_bad++; $display("FAIL garbage_done: got %b required 1", bus.done);
        end
    endtask

    task automatic test_overflow();
        clear_logs();
        bq.delete();
        bq.push_back(8'hA5);
        bq.push_back(8'h10);
        bq.push_back(8'h01);
        send_bq(1);
        settle();
        n_cmp++;
        if (wr_data_q.size() !== 0) begin
            n_bad++; $display("FAIL overflow_wen_count: got %0d required 0", wr_data_q.size());
        end
        n_cmp++;
        if ({bus.err, bus.done, bus.loading} !== 3'b100) begin
            n_bad++;
            $display("FAIL overflow_flags: err,done,loading=%b required 100",
                     {bus.err, bus.done, bus.loading});
        end
        // A following good frame must clear err and load normally
        clear_logs();
        random_words(3);
        build_frame();
        send_bq(1);
        settle();
        n_cmp++;
        if ({bus.err, bus.done} !== 2'b01) begin
            n_bad++;
            $display("FAIL overflow_recover_flags: err,done=%b required 01", {bus.err, bus.done});
        end
        n_cmp++;
        if (wr_data_q.size() !== fw.size()) begin
            n_bad++;
            $display("FAIL overflow_recover_count: got %0d required %0d", wr_data_q.size(), fw.size());
        end else begin
            foreach (fw[i]) begin
                n_cmp++;
                if (wr_addr_q[i] !== i || wr_data_q[i] !== fw[i]) begin
                    n_bad++;
                    $display("FAIL overflow_recover_word: addr %0d data %0h required addr %0d data %0h",
                             wr_addr_q[i], wr_data_q[i], i, fw[i]);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        clear_logs();
        fw.delete();
        build_frame();
        send_bq(1);
        settle();
        n_cmp++;
        if (wr_data_q.size() !== 0) begin
            n_bad++; $display("FAIL zero_len_wen_count: got %0d required 0", wr_data_q.size());
        end
        n_cmp++;
        if ({bus.done, bus.err, bus.loading} !== 3'b100) begin
            n_bad++;
            $display("FAIL zero_len_flags: done,err,loading=%b required 100",
                     {bus.done, bus.err, bus.loading});
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        random_words(2);
        build_frame();
        send_bq(0);
        settle();
        n_cmp++;
        if (wen_cyc_q.size() !== 2 || acc_cyc_q.size() < 11) begin
            n_bad++;
            $display("FAIL stream_counts: wEn %0d accepted %0d required 2 and at least 11",
                     wen_cyc_q.size(), acc_cyc_q.size());
        end else begin
            n_cmp++;
            if (wen_cyc_q[0] - acc_cyc_q[3] !== 4 || wen_cyc_q[1] - acc_cyc_q[3] !== 9) begin
                n_bad++;
                $display("FAIL stream_timing: writes at +%0d and +%0d required +4 and +9",
                         wen_cyc_q[0] - acc_cyc_q[3], wen_cyc_q[1] - acc_cyc_q[3]);
            end
            n_cmp++;
            if (wr_data_q[0] !== fw[0] || wr_data_q[1] !== fw[1]) begin
                n_bad++;
                $display("FAIL stream_data: got %0h %0h required %0h %0h",
                         wr_data_q[0], wr_data_q[1], fw[0], fw[1]);
            end
        end
        n_cmp++;
        if (ready_in_write !== 0) begin
            n_bad++; $display("FAIL stream_backpressure: rx_ready high in %0d write cycles, required 0",
                              ready_in_write);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            clear_logs();
            random_words($urandom_range(8, 1));
            // Sync value inside the payload must be treated as data
            if (f == 0) fw[0] = 32'hA5A5A5A5;
            build_frame();
            send_bq(3);
            settle();
            n_cmp++;
            if (wr_data_q.size() !== fw.size()) begin
                n_bad++;
                $display("FAIL random_count: frame %0d got %0d required %0d", f, wr_data_q.size(), fw.size());
            end else begin
                foreach (fw[i]) begin
                    n_cmp++;
                    if (wr_addr_q[i] !== i || wr_data_q[i] !== fw[i]) begin
                        n_bad++;
                        $display("FAIL random_word: frame %0d addr %0d data %0h required addr %0d data %0h",
                                 f, wr_addr_q[i], wr_data_q[i], i, fw[i]);
                    end
                end
            end
            n_cmp++;
            if ({bus.done, bus.err} !== 2'b10) begin
                n_bad++;
                $display("FAIL random_flags: frame %0d done,err=%b required 10", f, {bus.done, bus.err});
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        random_words(2);
        build_frame();
        // Sync, two length bytes, word 0, then two bytes of word 1
        for (int i = 0; i < 9; i++) send_byte(bq[i], 1);
        bus.rx_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.wEn, bus.loading, bus.done, bus.err, bus.rx_ready} !== 5'b00001 ||
            bus.writeAddr !== 12'h000 || bus.dataIn !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: flags %b addr %0h data %0h required 00001 0 0",
                     {bus.wEn, bus.loading, bus.done, bus.err, bus.rx_ready}, bus.writeAddr, bus.dataIn);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        settle();
        n_cmp++;
        if (wr_data_q.size() !== 1) begin
            n_bad++; $display("FAIL reset_mid_wen_count: got %0d required 1", wr_data_q.size());
        end
        n_cmp++;
        if (rom[0] !== fw[0]) begin
            n_bad++; $display("FAIL reset_mid_word0: got %0h required %0h", rom[0], fw[0]);
        end
        n_cmp++;
        if ({bus.loading, bus.done, bus.err} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_mid_flags: loading,done,err=%b required 000",
                     {bus.loading, bus.done, bus.err});
        end
    endtask

`ifdef ROM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] last_b;
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            last_b = (k == 0) ? 8'h05 : 8'hFF;
            bq.delete();
            bq.push_back(8'hA5); bq.push_back(8'h00); bq.push_back(8'h01);
            bq.push_back(8'h01); bq.push_back(8'h02); bq.push_back(8'h03); bq.push_back(8'h04);
            bq.push_back(last_b);
            send_bq(1);
            settle();
            n_cmp++;
            if ({bus.done, bus.err, bus.loading} !== ((k == 0) ? 3'b100 : 3'b010)) begin
                n_bad++;
                $display("FAIL checksum_flags: case %0d done,err,loading=%b required %b", k,
                         {bus.done, bus.err, bus.loading}, (k == 0) ? 3'b100 : 3'b010);
            end
            n_cmp++;
            if (wr_data_q.size() !== 1 || rom[0] !== 32'h01020304) begin
                n_bad++;
                $display("FAIL checksum_word: case %0d writes %0d addr0 %0h required 1 and 01020304",
                         k, wr_data_q.size(), rom[0]);
            end
        end
    endtask
`endif

    task automatic test_full_depth();
        int bad_words;
        clear_logs();
        random_words(DEPTH);
        build_frame();
        send_bq(0);
        settle();
        n_cmp++;
        if (wr_data_q.size() !== DEPTH) begin
            n_bad++; $display("FAIL full_depth_count: got %0d required %0d", wr_data_q.size(), DEPTH);
        end else begin
            bad_words = 0;
            foreach (fw[i]) if (wr_addr_q[i] !== i || wr_data_q[i] !== fw[i]) bad_words++;
            n_cmp++;
            if (bad_words !== 0) begin
                n_bad++; $display("FAIL full_depth_data: %0d wrong words, required 0", bad_words);
            end
        end
        n_cmp++;
        if ({bus.done, bus.err} !== 2'b10) begin
            n_bad++; $display("FAIL full_depth_flags: done,err=%b required 10", {bus.done, bus.err});
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        test_reset();
        test_basic();
        test_garbage();
        test_overflow();
        test_zero_len();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef ROM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_full_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
